if_fetch: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues one outstanding word request to instruction memory over a grant/rvalid handshake.
- Presents one buffered instruction per cycle to IF/ID as if_ins, PC and PC_plus_4.
- Honours the branch delay slot: the instruction after a branch/jump is always fetched. Applies CP0 redirects (SYSCALL/ERET) with flush.

---
 rtl/if_fetch_if.sv | 25 ++
 rtl/if_fetch.sv | 156 +++++++++++++++
 tb/tb_if_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// One outstanding word request: req/gnt handshake, then rvalid with rdata.
interface if_fetch_if;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding IF/ID: owns the fetch PC, one outstanding imem request and a
// single-entry instruction buffer. Define IF_PERF_CNT_EN to add wait-cycle and flush counters.
module if_fetch #(
   parameter logic [29:0] RESET_PC = 30'h2FF0_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        hazard,
   input  logic        Branch_ok,
   input  logic [29:0] BranchTarget,
   input  logic [1:0]  id_Jump,
   input  logic [29:0] JumpTarget,
   input  logic        cp0_redirect,
   input  logic [29:0] cp0_target,
   if_fetch_if.master  imem,
   output logic [31:0] if_ins,
   output logic [29:0] PC,
   output logic [29:0] PC_plus_4,
   output logic        if_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_wait_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {StBoot, StReq, StWait, StDiscard} state_e;

   state_e      state_q, state_d;
   logic [29:0] fetch_pc_q, fetch_pc_d;
   logic [29:0] inflight_pc_q, inflight_pc_d;
   logic        pend_valid_q, pend_valid_d;
   logic [29:0] pend_target_q, pend_target_d;
   logic [31:0] ins_q, ins_d;
   logic [29:0] pc_q, pc_d;
   logic        valid_q, valid_d;

   logic        redir;
   logic [29:0] target;
   logic        secured;
   logic        pend_hit;
   logic        eff_pend_valid;
   logic [29:0] eff_pend_target;
   logic [29:0] cur_pc;
   logic        req;
   logic        consume;

   assign redir   = !cp0_redirect && (Branch_ok || (id_Jump != 2'b00));
   assign target  = Branch_ok ? BranchTarget : JumpTarget;
   // Delay slot already buffered or in flight: the target is the very next fetch.
   assign secured = valid_q || (state_q == StWait);
   assign pend_hit        = redir && !secured;
   assign eff_pend_valid  = pend_valid_q || pend_hit;
   assign eff_pend_target = pend_hit ? target : pend_target_q;
   assign cur_pc  = (redir && secured) ? target : fetch_pc_q;
   assign req     = (state_q == StReq) && !cp0_redirect && !(valid_q && hazard);
   assign consume = valid_q && !hazard;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = cur_pc;
      inflight_pc_d = inflight_pc_q;
      pend_valid_d  = eff_pend_valid;
      pend_target_d = eff_pend_target;
      ins_d         = ins_q;
      pc_d          = pc_q;
      valid_d       = valid_q;

      if (consume) begin
         ins_d   = '0;
         valid_d = 1'b0;
      end

      if (cp0_redirect) begin
         ins_d        = '0;
         valid_d      = 1'b0;
         pend_valid_d = 1'b0;
         fetch_pc_d   = cp0_target;
      end

      unique case (state_q)
         StBoot: state_d = StReq;
         StReq: begin
            if (req && imem.imem_gnt) begin
               state_d       = StWait;
               inflight_pc_d = cur_pc;
               fetch_pc_d    = eff_pend_valid ? eff_pend_target : cur_pc + 30'd1;
               pend_valid_d  = 1'b0;
            end
         end
         StWait: begin
            if (imem.imem_rvalid) begin
               state_d = StReq;
               if (!cp0_redirect) begin
                  ins_d   = imem.imem_rdata;
                  pc_d    = inflight_pc_q;
                  valid_d = 1'b1;
               end
            end else if (cp0_redirect) begin
               state_d = StDiscard;
            end
         end
         StDiscard: begin
            if (imem.imem_rvalid) state_d = StReq;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q       <= StBoot;
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= '0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         ins_q         <= '0;
         pc_q          <= '0;
         valid_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         ins_q         <= ins_d;
         pc_q          <= pc_d;
         valid_q       <= valid_d;
      end
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = cur_pc;
   assign if_ins         = ins_q;
   assign PC             = pc_q;
   assign PC_plus_4      = pc_q + 30'd1;
   assign if_valid       = valid_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] wait_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         wait_cnt_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         if ((state_q == StWait) || (state_q == StDiscard)) wait_cnt_q <= wait_cnt_q + 32'd1;
         if (cp0_redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign perf_wait_cnt  = wait_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: boot vector table, directed redirect/hazard/reset sequences, then random
// traffic checked every cycle against a transaction-level model of the fetch stage.
module tb_if_fetch;

   localparam logic [29:0] RstPc = 30'h2FF0_0000;

   logic        clk = 1'b0;
   logic        Reset;
   logic        hazard;
   logic        Branch_ok;
   logic [29:0] BranchTarget;
   logic [1:0]  id_Jump;
   logic [29:0] JumpTarget;
   logic        cp0_redirect;
   logic [29:0] cp0_target;
   logic [31:0] if_ins;
   logic [29:0] PC;
   logic [29:0] PC_plus_4;
   logic        if_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_wait_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   if_fetch_if imem ();

   if_fetch #(.RESET_PC(RstPc)) dut (
      .Clk          (clk),
      .Reset        (Reset),
      .hazard       (hazard),
      .Branch_ok    (Branch_ok),
      .BranchTarget (BranchTarget),
      .id_Jump      (id_Jump),
      .JumpTarget   (JumpTarget),
      .cp0_redirect (cp0_redirect),
      .cp0_target   (cp0_target),
      .imem         (imem),
      .if_ins       (if_ins),
      .PC           (PC),
      .PC_plus_4    (PC_plus_4),
      .if_valid     (if_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_wait_cnt  (perf_wait_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Memory responder state.
   logic        m_busy = 1'b0;
   int          m_lat = 0;
   logic [29:0] m_addr = '0;
   logic        rand_mode = 1'b0;
   logic        hold_gnt = 1'b0;
   int          fix_lat = 1;
   logic        s_req;
   logic [29:0] s_addr;

   // Reference model: outstanding transaction, buffer, next fetch address, pending target.
   logic        m_started;
   logic        o_v, o_drop;
   logic [29:0] o_pc;
   logic        b_v;
   logic [31:0] b_ins;
   logic [29:0] b_pc;
   logic [29:0] nxt;
   logic        p_v;
   logic [29:0] p_t;
   logic        e_req, e_redir, e_sec;
   logic [29:0] e_addr, e_tgt;

   function automatic logic [31:0] word_of(input logic [29:0] a);
      return {a, 2'b11} ^ 32'h5A3C_C3A5;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      o_v = 1'b0; o_drop = 1'b0; o_pc = '0;
      b_v = 1'b0; b_ins = '0; b_pc = '0;
      nxt = RstPc;
      p_v = 1'b0; p_t = '0;
   endtask

   task automatic model_update();
      if (!Reset) begin
         model_reset();
         return;
      end
      if (cp0_redirect) begin
         b_v = 1'b0; b_ins = '0; p_v = 1'b0; nxt = cp0_target;
         if (o_v) begin
            if (imem.imem_rvalid) o_v = 1'b0;
            else o_drop = 1'b1;
         end
      end else begin
         if (b_v && !hazard) begin
            b_v = 1'b0; b_ins = '0;
         end
         if (e_redir) begin
            if (e_sec) nxt = e_tgt;
            else begin
               p_v = 1'b1; p_t = e_tgt;
            end
         end
         if (o_v && imem.imem_rvalid) begin
            o_v = 1'b0;
            if (!o_drop) begin
               b_v = 1'b1; b_ins = imem.imem_rdata; b_pc = o_pc;
            end
         end
         if (e_req && imem.imem_gnt) begin
            o_v = 1'b1; o_drop = 1'b0; o_pc = nxt;
            nxt = p_v ? p_t : 30'(nxt + 30'd1);
            p_v = 1'b0;
         end
      end
      m_started = 1'b1;
   endtask

   // Drive memory response for this cycle, then compare DUT against the model at negedge.
   task automatic pre();
      imem.imem_rvalid = m_busy && (m_lat == 1);
      imem.imem_rdata  = imem.imem_rvalid ? word_of(m_addr) : $urandom;
      imem.imem_gnt    = !m_busy && !hold_gnt && (!rand_mode || ($urandom_range(0, 2) != 0));
      @(negedge clk);
      e_redir = !cp0_redirect && (Branch_ok || (id_Jump != 2'b00));
      e_tgt   = Branch_ok ? BranchTarget : JumpTarget;
      e_sec   = b_v || (o_v && !o_drop);
      e_req   = m_started && !o_v && !cp0_redirect && !(b_v && hazard);
      e_addr  = (e_redir && e_sec) ? e_tgt : nxt;
      chk("req", imem.imem_req, e_req);
      if (e_req) chk("addr", imem.imem_addr, e_addr);
      chk("valid", if_valid, b_v);
      chk("ins", if_ins, b_v ? b_ins : 32'h0);
      chk("pc", PC, b_pc);
      chk("pc4", PC_plus_4, 30'(b_pc + 30'd1));
   endtask

   task automatic post();
      s_req  = imem.imem_req;
      s_addr = imem.imem_addr;
      @(posedge clk);
      model_update();
      if (m_busy) begin
         if (m_lat == 1) m_busy = 1'b0;
         else m_lat--;
      end else if (s_req && imem.imem_gnt) begin
         m_busy = 1'b1;
         m_addr = s_addr;
         m_lat  = rand_mode ? int'($urandom_range(1, 3)) : fix_lat;
      end
      #1;
      Branch_ok = 1'b0;
      id_Jump = 2'b00;
      cp0_redirect = 1'b0;
   endtask

   task automatic tick();
      pre();
      post();
   endtask

   task automatic goto_req();
      int n = 0;
      while (!(m_started && !o_v) && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         total++; bad++;
         $display("FAIL goto_req: got no REQ state want REQ within 20 cycles");
      end
   endtask

   typedef struct {
      logic        rst;
      logic        req;
      logic [29:0] addr;
      logic        valid;
      logic [29:0] pc;
      logic [29:0] pc4;
      logic [31:0] ins;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1);
   end

   initial begin
      logic [29:0] hold_pc;
      logic [31:0] hold_ins;

      Reset = 1'b0; hazard = 1'b0; Branch_ok = 1'b0; BranchTarget = '0;
      id_Jump = 2'b00; JumpTarget = '0; cp0_redirect = 1'b0; cp0_target = '0;
      imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
      model_reset();
      @(posedge clk);
      #1;

      // Boot with zero-wait memory: one instruction every two cycles from RESET_PC.
      tbl[0] = '{1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 30'h1, 32'h0};
      tbl[1] = '{1'b0, 1'b0, 30'h0, 1'b0, 30'h0, 30'h1, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 30'h0, 1'b0, 30'h0, 30'h1, 32'h0};
      tbl[3] = '{1'b1, 1'b1, RstPc, 1'b0, 30'h0, 30'h1, 32'h0};
      tbl[4] = '{1'b1, 1'b0, 30'h0, 1'b0, 30'h0, 30'h1, 32'h0};
      tbl[5] = '{1'b1, 1'b1, 30'h2FF0_0001, 1'b1, RstPc, 30'h2FF0_0001, word_of(RstPc)};
      tbl[6] = '{1'b1, 1'b0, 30'h0, 1'b0, RstPc, 30'h2FF0_0001, 32'h0};
      tbl[7] = '{1'b1, 1'b1, 30'h2FF0_0002, 1'b1, 30'h2FF0_0001, 30'h2FF0_0002,
                 word_of(30'h2FF0_0001)};
      for (int i = 0; i < 8; i++) begin
         Reset = tbl[i].rst;
         pre();
         chk($sformatf("tbl%0d_req", i), imem.imem_req, tbl[i].req);
         if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem.imem_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_valid", i), if_valid, tbl[i].valid);
         chk($sformatf("tbl%0d_pc", i), PC, tbl[i].pc);
         chk($sformatf("tbl%0d_pc4", i), PC_plus_4, tbl[i].pc4);
         chk($sformatf("tbl%0d_ins", i), if_ins, tbl[i].ins);
         post();
      end

      // Branch while delay slot 0x21 is in flight: 0x21 delivered, then fetch 0x100.
      goto_req();
      cp0_redirect = 1'b1; cp0_target = 30'h20; tick();
      tick();
      tick();
      pre(); chk("br_slot_addr", imem.imem_addr, 30'h21); post();
      Branch_ok = 1'b1; BranchTarget = 30'h100; tick();
      pre();
      chk("br_slot_valid", if_valid, 1'b1);
      chk("br_slot_pc", PC, 30'h21);
      chk("br_tgt_req", imem.imem_req, 1'b1);
      chk("br_tgt_addr", imem.imem_addr, 30'h100);
      post();

      // Jump in REQ with empty buffer: delay slot 0x31 fetched first, then 0x200.
      goto_req();
      cp0_redirect = 1'b1; cp0_target = 30'h31; tick();
      hold_gnt = 1'b1; id_Jump = 2'b10; JumpTarget = 30'h200;
      pre(); chk("jmp_pend_addr", imem.imem_addr, 30'h31); post();
      hold_gnt = 1'b0;
      pre(); chk("jmp_slot_addr", imem.imem_addr, 30'h31); post();
      tick();
      pre();
      chk("jmp_slot_pc", PC, 30'h31);
      chk("jmp_tgt_addr", imem.imem_addr, 30'h200);
      post();

      // CP0 redirect mid-WAIT with a simultaneous branch: late data dropped, fetch 0x60, 0x61.
      fix_lat = 3;
      goto_req();
      tick();
      cp0_redirect = 1'b1; cp0_target = 30'h60; Branch_ok = 1'b1; BranchTarget = 30'h300;
      tick();
      pre(); chk("cp0_disc_valid", if_valid, 1'b0); post();
      pre(); chk("cp0_drop_valid", if_valid, 1'b0); post();
      pre();
      chk("cp0_after_valid", if_valid, 1'b0);
      chk("cp0_after_addr", imem.imem_addr, 30'h60);
      post();
      goto_req();
      pre();
      chk("cp0_seq_pc", PC, 30'h60);
      chk("cp0_seq_addr", imem.imem_addr, 30'h61);
      post();

      // Hazard holds the buffer and blocks requests; release issues a request at once.
      fix_lat = 1;
      goto_req();
      tick();
      tick();
      hold_pc = b_pc;
      hold_ins = word_of(b_pc);
      hazard = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pre();
         chk($sformatf("hz%0d_req", i), imem.imem_req, 1'b0);
         chk($sformatf("hz%0d_pc", i), PC, hold_pc);
         chk($sformatf("hz%0d_ins", i), if_ins, hold_ins);
         post();
      end
      hazard = 1'b0;
      pre(); chk("hz_release_req", imem.imem_req, 1'b1); post();

      // Reset mid-WAIT: stale rvalid after release is ignored, fetch restarts at RESET_PC.
      fix_lat = 3;
      goto_req();
      tick();
      Reset = 1'b0; tick();
      Reset = 1'b1;
      pre(); chk("rst_boot_req", imem.imem_req, 1'b0); post();
      pre();
      chk("rst_stale_valid", if_valid, 1'b0);
      chk("rst_restart_addr", imem.imem_addr, RstPc);
      post();
      pre(); chk("rst_after_valid", if_valid, 1'b0); post();

      // Random traffic against the model.
      fix_lat = 1;
      rand_mode = 1'b1;
      for (int n = 0; n < 2500; n++) begin
         Reset        = ($urandom_range(0, 199) != 0);
         hazard       = ($urandom_range(0, 3) == 0);
         Branch_ok    = ($urandom_range(0, 9) == 0);
         BranchTarget = 30'($urandom);
         id_Jump      = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         JumpTarget   = 30'($urandom);
         cp0_redirect = ($urandom_range(0, 24) == 0);
         cp0_target   = 30'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
